// File: rtl/mips_pkg.sv
// Shared MIPS pipeline widths, load-type encodings and the MEM/WB register layout.
// Load-type codes 101-111 are not listed here; they fall through to word loads.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic              link_sel;
        logic [2:0]        load_type;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] pc_plus8;
        logic [ADDR_W-1:0] dest_addr;
    } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Big-endian byte/halfword selection and extension of an aligned memory word.
// The misalign flag reflects address and load type only; the caller gates it.
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        offset,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] value,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        byte_sel = 8'd0;
        case (offset)
            2'd0:    byte_sel = data[31:24];
            2'd1:    byte_sel = data[23:16];
            2'd2:    byte_sel = data[15:8];
            default: byte_sel = data[7:0];
        endcase
        half_sel = offset[1] ? data[15:0] : data[31:16];
    end

    always_comb begin
        value    = data;
        misalign = 1'b0;
        case (load_type)
            LT_LB: value = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU: value = {24'd0, byte_sel};
            LT_LH: begin
                value    = {{16{half_sel[15]}}, half_sel};
                misalign = offset[0];
            end
            LT_LHU: begin
                value    = {16'd0, half_sel};
                misalign = offset[0];
            end
            default: begin
                value    = data;
                misalign = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load extension, register-file write port,
// operand bypass, sticky misaligned-load capture and retired-instruction counter.
module wb_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              InValid,
    input  logic              Flush,
    input  logic              RegWriteIn,
    input  logic              MemToReg,
    input  logic              LinkSel,
    input  logic [2:0]        LoadType,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [DATA_W-1:0] PcPlus8,
    input  logic [ADDR_W-1:0] DestAddr,
    input  logic [ADDR_W-1:0] RfAddr1,
    input  logic [ADDR_W-1:0] RfAddr2,
    input  logic [DATA_W-1:0] RfData1,
    input  logic [DATA_W-1:0] RfData2,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic [DATA_W-1:0] OpA,
    output logic [DATA_W-1:0] OpB,
    output logic              MisalignErr,
    output logic [DATA_W-1:0] MisalignAddr,
    output logic [DATA_W-1:0] RetireCount
);

    mem_wb_t           wb_q;
    logic              misalign_err_q;
    logic [DATA_W-1:0] misalign_addr_q;
    logic [DATA_W-1:0] retire_q;

    logic [DATA_W-1:0] load_value;
    logic              load_misalign;
    logic              misaligned;

    load_align u_load_align (
        .data      (wb_q.mem_data),
        .offset    (wb_q.alu_result[1:0]),
        .load_type (wb_q.load_type),
        .value     (load_value),
        .misalign  (load_misalign)
    );

    assign misaligned = wb_q.valid & wb_q.mem_to_reg & load_misalign;

    // Flush only kills the incoming valid bit; the payload is captured regardless.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wb_q            <= '0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
            retire_q        <= '0;
        end else begin
            wb_q.valid      <= InValid & ~Flush;
            wb_q.reg_write  <= RegWriteIn;
            wb_q.mem_to_reg <= MemToReg;
            wb_q.link_sel   <= LinkSel;
            wb_q.load_type  <= LoadType;
            wb_q.alu_result <= AluResult;
            wb_q.mem_data   <= MemReadData;
            wb_q.pc_plus8   <= PcPlus8;
            wb_q.dest_addr  <= DestAddr;
            if (misaligned) begin
                misalign_err_q <= 1'b1;
                if (!misalign_err_q) begin
                    misalign_addr_q <= wb_q.alu_result;
                end
            end
            if (wb_q.valid && !misaligned) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    always_comb begin
        if (wb_q.link_sel) begin
            WriteData = wb_q.pc_plus8;
        end else if (wb_q.mem_to_reg) begin
            WriteData = load_value;
        end else begin
            WriteData = wb_q.alu_result;
        end
    end

    // r0 is excluded here, which also keeps it out of the bypass below.
    assign RegWrite  = wb_q.valid & wb_q.reg_write & (wb_q.dest_addr != '0) & ~misaligned;
    assign WriteAddr = wb_q.dest_addr;

    assign OpA = (RegWrite && (RfAddr1 == WriteAddr)) ? WriteData : RfData1;
    assign OpB = (RegWrite && (RfAddr2 == WriteAddr)) ? WriteData : RfData2;

    assign MisalignErr  = misalign_err_q;
    assign MisalignAddr = misalign_addr_q;
    assign RetireCount  = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: each driven entry pushes its expected WB-cycle outputs,
// which are popped and compared one cycle later.
module tb_wb_stage;

    localparam int EW = 103;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        InValid = 1'b0, Flush = 1'b0, RegWriteIn = 1'b0;
    logic        MemToReg = 1'b0, LinkSel = 1'b0;
    logic [2:0]  LoadType = 3'd0;
    logic [31:0] AluResult = '0, MemReadData = '0, PcPlus8 = '0;
    logic [4:0]  DestAddr = '0, RfAddr1 = '0, RfAddr2 = '0;
    logic [31:0] RfData1 = '0, RfData2 = '0;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData, OpA, OpB, MisalignAddr, RetireCount;
    logic        RegWrite, MisalignErr;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_maddr = '0;
    logic [31:0] m_cnt = '0;

    wb_stage dut (
        .clk(clk), .Reset(Reset), .InValid(InValid), .Flush(Flush),
        .RegWriteIn(RegWriteIn), .MemToReg(MemToReg), .LinkSel(LinkSel),
        .LoadType(LoadType), .AluResult(AluResult), .MemReadData(MemReadData),
        .PcPlus8(PcPlus8), .DestAddr(DestAddr), .RfAddr1(RfAddr1), .RfAddr2(RfAddr2),
        .RfData1(RfData1), .RfData2(RfData2), .WriteAddr(WriteAddr),
        .WriteData(WriteData), .RegWrite(RegWrite), .OpA(OpA), .OpB(OpB),
        .MisalignErr(MisalignErr), .MisalignAddr(MisalignAddr), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_wdata(input logic link, input logic m2r,
            input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] mem,
            input logic [31:0] pc8);
        logic [31:0] b;
        logic [31:0] h;
        b = mem >> (8 * (3 - alu[1:0]));
        h = mem >> (16 * (1 - alu[1]));
        if (link) return pc8;
        if (!m2r) return alu;
        case (lt)
            3'd1: return {{24{b[7]}}, b[7:0]};
            3'd2: return {24'd0, b[7:0]};
            3'd3: return {{16{h[15]}}, h[15:0]};
            3'd4: return {16'd0, h[15:0]};
            default: return mem;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] lt, input logic [31:0] alu);
        if (lt == 3'd1 || lt == 3'd2) return 1'b0;
        if (lt == 3'd3 || lt == 3'd4) return alu[0];
        return alu[1:0] != 2'd0;
    endfunction

    task automatic check_wb();
        logic [EW-1:0] rec;
        logic          e_rw;
        logic [4:0]    e_addr;
        logic [31:0]   e_wd;
        rec = exp_q.pop_front();
        e_rw = rec[102];
        e_addr = rec[101:97];
        e_wd = rec[96:65];
        RfAddr1 = e_addr;
        RfData1 = $urandom;
        RfAddr2 = ($urandom_range(1, 0) == 1) ? e_addr : 5'($urandom_range(31, 0));
        RfData2 = $urandom;
        #1;
        check("reg_write", 32'(RegWrite), 32'(e_rw));
        check("write_addr", 32'(WriteAddr), 32'(e_addr));
        check("write_data", WriteData, e_wd);
        check("misalign_err", 32'(MisalignErr), 32'(rec[64]));
        check("misalign_addr", MisalignAddr, rec[63:32]);
        check("retire_count", RetireCount, rec[31:0]);
        check("op_a", OpA, (e_rw && RfAddr1 == e_addr) ? e_wd : RfData1);
        check("op_b", OpB, (e_rw && RfAddr2 == e_addr) ? e_wd : RfData2);
    endtask

    task automatic step(input logic valid, input logic flush, input logic rw,
            input logic m2r, input logic link, input logic [2:0] lt,
            input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc8,
            input logic [4:0] dest);
        logic v, mis, e_rw;
        InValid = valid; Flush = flush; RegWriteIn = rw; MemToReg = m2r;
        LinkSel = link; LoadType = lt; AluResult = alu; MemReadData = mem;
        PcPlus8 = pc8; DestAddr = dest;
        v = valid & ~flush;
        mis = v & m2r & model_mis(lt, alu);
        e_rw = v & rw & (dest != 5'd0) & ~mis;
        exp_q.push_back({e_rw, dest, model_wdata(link, m2r, lt, alu, mem, pc8),
                         m_err, m_maddr, m_cnt});
        if (mis && !m_err) m_maddr = alu;
        if (mis) m_err = 1'b1;
        if (v && !mis) m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
        check_wb();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, $urandom, $urandom, $urandom, 5'd3);
    endtask

    // Reset is applied together with a valid incoming entry, which must be lost.
    task automatic do_reset();
        Reset = 1'b1; InValid = 1'b1; Flush = 1'b0; RegWriteIn = 1'b1;
        MemToReg = 1'b0; LinkSel = 1'b1; AluResult = $urandom; PcPlus8 = $urandom;
        DestAddr = 5'd9;
        @(posedge clk);
        #1;
        Reset = 1'b0; InValid = 1'b0;
        exp_q.delete();
        m_err = 1'b0; m_maddr = '0; m_cnt = '0;
        RfAddr1 = 5'd9; RfAddr2 = 5'd0; RfData1 = $urandom; RfData2 = $urandom;
        #1;
        check("rst_reg_write", 32'(RegWrite), 32'd0);
        check("rst_write_data", WriteData, 32'd0);
        check("rst_misalign_err", 32'(MisalignErr), 32'd0);
        check("rst_misalign_addr", MisalignAddr, 32'd0);
        check("rst_retire_count", RetireCount, 32'd0);
        check("rst_op_a", OpA, RfData1);
        check("rst_op_b", OpB, RfData2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Byte loads, big-endian offsets.
        step(1, 0, 1, 1, 0, 3'd1, 32'h0000_1001, 32'h12F4_5678, 32'h0, 5'd5);
        step(1, 0, 1, 1, 0, 3'd2, 32'h0000_1001, 32'h12F4_5678, 32'h0, 5'd5);
        step(1, 0, 1, 1, 0, 3'd1, 32'h0000_1000, 32'h8234_5678, 32'h0, 5'd6);
        step(1, 0, 1, 1, 0, 3'd2, 32'h0000_1003, 32'h1234_56F8, 32'h0, 5'd6);
        step(1, 0, 1, 1, 0, 3'd3, 32'h0000_1000, 32'h9ABC_1234, 32'h0, 5'd8);
        step(1, 0, 1, 1, 0, 3'd3, 32'h0000_1002, 32'h1234_9ABC, 32'h0, 5'd8);
        step(1, 0, 1, 1, 0, 3'd4, 32'h0000_1002, 32'h1234_9ABC, 32'h0, 5'd8);
        step(1, 0, 1, 1, 0, 3'd0, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 5'd10);
        step(1, 0, 1, 1, 0, 3'd6, 32'h0000_1008, 32'h0BAD_CAFE, 32'h0, 5'd11);

        // Bypass, r0 write suppression, link select, flush.
        step(1, 0, 1, 0, 0, 3'd0, 32'hDEAD_BEEF, $urandom, $urandom, 5'd7);
        step(1, 0, 1, 0, 0, 3'd0, 32'hDEAD_BEEF, $urandom, $urandom, 5'd0);
        step(1, 0, 1, 0, 1, 3'd0, $urandom, $urandom, 32'h0040_0010, 5'd31);
        step(1, 1, 1, 0, 0, 3'd0, $urandom, $urandom, $urandom, 5'd9);
        idle();

        // Misaligned loads: only the first address is recorded.
        step(1, 0, 1, 1, 0, 3'd3, 32'h0000_2003, $urandom, $urandom, 5'd4);
        step(1, 0, 1, 1, 0, 3'd0, 32'h0000_3002, $urandom, $urandom, 5'd6);
        idle();
        idle();

        for (int i = 0; i < 150; i++) begin
            step(($urandom_range(9, 0) < 8), ($urandom_range(9, 0) == 0),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 ($urandom_range(9, 0) == 0), 3'($urandom_range(7, 0)),
                 $urandom, $urandom, $urandom, 5'($urandom_range(31, 0)));
        end

        // Counter wrap from an all-ones value.
        idle();
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        m_cnt = 32'hFFFF_FFFF;
        step(1, 0, 1, 0, 0, 3'd0, $urandom, $urandom, $urandom, 5'd12);
        idle();
        idle();

        // Reset in the middle of traffic.
        step(1, 0, 1, 0, 0, 3'd0, $urandom, $urandom, $urandom, 5'd13);
        do_reset();
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL have one clock, clk; reset is synchronous and active-high, named Reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 InValid  input  1  MEM-stage result valid this cycle.
REQ-005 Flush  input  1  discard the entry being captured this cycle.
REQ-006 RegWriteIn  input  1  instruction writes a register.
REQ-007 MemToReg  input  1  write data comes from memory (load).
REQ-008 LinkSel  input  1  write data is PcPlus8 (JAL/JALR).
REQ-009 LoadType  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 are treated as LW.
REQ-010 AluResult  input  32  ALU result / effective address.
REQ-011 MemReadData  input  32  aligned memory word.
REQ-012 PcPlus8  input  32  link value.
REQ-013 DestAddr  input  5  destination register.
REQ-014 RfAddr1, RfAddr2  input  5 each  register-file read addresses.
REQ-015 RfData1, RfData2  input  32 each  register-file read data.
REQ-016 WriteAddr, WriteData, RegWrite  output  5/32/1  register-file write port.
REQ-017 OpA, OpB  output  32 each  bypassed operands.
REQ-018 MisalignErr  output  1  sticky misaligned-load flag.
REQ-019 MisalignAddr  output  32  address of the first misaligned load.
REQ-020 RetireCount  output  32  retired-instruction count.

Function
REQ-021 The block SHALL hold one MEM/WB pipeline register (valid plus all data/control inputs), updated every rising clk edge.
REQ-022 Capture rule: valid_q <= InValid & ~Flush; data fields are captured unconditionally.
REQ-023 Latency: exactly one cycle from input to the register-file write port.
REQ-024 WriteData priority: LinkSel_q -> PcPlus8_q; else MemToReg_q -> load-extended data; else AluResult_q.
REQ-025 Load extension SHALL be big-endian: byte offset = AluResult_q[1:0], where offset 0 selects bits 31:24 and halfword offset 0 selects bits 31:16; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 Misaligned: MemToReg_q & valid_q & ((LH/LHU & addr[0]) | (LW & addr[1:0]!=0)).
REQ-027 RegWrite SHALL be valid_q & RegWriteIn_q & (DestAddr_q != 0) & ~misaligned; WriteAddr = DestAddr_q.
REQ-028 On a misaligned load, MisalignErr SHALL set on the next edge and remain set until Reset; MisalignAddr is captured only when MisalignErr is 0, so it records the first event only.
REQ-029 RetireCount SHALL increment by 1 at each edge where valid_q=1 and the load is not misaligned, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 OpA SHALL equal WriteData when RegWrite=1 and RfAddr1==WriteAddr, otherwise RfData1; OpB follows the same rule with RfAddr2/RfData2.
REQ-031 OpA/OpB SHALL be combinational, with no added latency.
REQ-032 Address 0 SHALL never be bypassed; this follows from REQ-027.
REQ-033 Flush and InValid asserted in the same cycle: the entry is dropped, and the entry currently in WB still completes.

Reset
REQ-034 On Reset, all registered state SHALL clear to 0: valid_q, control fields, MisalignErr, MisalignAddr, RetireCount.
REQ-035 In the cycle after Reset, RegWrite=0, WriteData=0, and OpA/OpB pass RfData1/RfData2.
REQ-036 Reset SHALL take priority over Flush, InValid and the counter increment.
REQ-037 An entry in flight when Reset asserts SHALL be lost without writing.

Structure
REQ-038 LoadType encodings and the width constants (32 data, 5 address) SHALL live in a shared package, mips_pkg.
REQ-039 Load alignment/extension SHALL be one combinational sub-module, load_align (inputs: data, offset, type; outputs: value, misalign).
REQ-040 The block SHALL total 120-400 lines of RTL.

Verification
REQ-041 LB at addr 0x...01 with MemReadData=0x12F45678, DestAddr=5 -> next cycle RegWrite=1, WriteAddr=5, WriteData=0xFFFFFFF4; LBU -> 0x000000F4.
REQ-042 LH at addr 0x...03 -> RegWrite=0, MisalignErr=1, MisalignAddr=addr; a second misaligned load at a different addr leaves MisalignAddr unchanged.
REQ-043 WB writes r7=0xDEADBEEF while RfAddr1=7, RfData1=0 -> OpA=0xDEADBEEF; with DestAddr=0 -> OpA=RfData1.
REQ-044 LinkSel=1, PcPlus8=0x00400010, DestAddr=31 -> WriteData=0x00400010; InValid=1 with Flush=1 -> RegWrite=0 next cycle and RetireCount unchanged.
REQ-045 Preload RetireCount to 0xFFFFFFFF via 2^32 retires or a forced value, then retire one -> 0; assert Reset mid-stream -> all outputs cleared next cycle.
